// File: rtl/bitwise_pipe.sv
// Pipelined NOT/AND/OR/XOR unit with STAGES elastic register stages and full backpressure.
// Ready ripples combinationally from out_ready back to in_ready; empty stages fill while stalled.
module bitwise_pipe #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CW     = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [CW-1:0]    count,
  output logic             busy
);

  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [CW-1:0]     count_q, count_d;
  logic [STAGES-1:0] adv;
  logic              in_rdy;
  logic              accept, deliver;
  logic [WIDTH-1:0]  result;

  always_comb begin
    result = '0;
    unique case (op)
      2'b00: result = ~a;
      2'b01: result = a & b;
      2'b10: result = a | b;
      2'b11: result = a ^ b;
      default: result = '0;
    endcase
  end

  // Walk from the output back to stage 0 so each stage sees whether its successor frees up.
  always_comb begin
    logic down_rdy;
    logic adv_k;
    down_rdy = out_ready;
    adv_k    = 1'b0;
    adv      = '0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      adv_k    = valid_q[k] & down_rdy;
      adv[k]   = adv_k;
      down_rdy = ~valid_q[k] | adv_k;
    end
    in_rdy = down_rdy;
  end

  assign accept  = in_valid & in_rdy;
  assign deliver = valid_q[STAGES-1] & out_ready;

  always_comb begin
    count_d = count_q;
    if (accept && !deliver) begin
      count_d = count_q + CW'(1);
    end else if (!accept && deliver) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      count_q <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        data_q[k] <= '0;
      end
    end else begin
      if (accept) begin
        valid_q[0] <= 1'b1;
        data_q[0]  <= result;
      end else if (adv[0]) begin
        valid_q[0] <= 1'b0;
      end
      for (int k = 1; k < int'(STAGES); k++) begin
        if (adv[k-1]) begin
          valid_q[k] <= 1'b1;
          data_q[k]  <= data_q[k-1];
        end else if (adv[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
      count_q <= count_d;
    end
  end

  // Data is never cleared on delivery, so an empty pipe keeps showing the last result.
  assign in_ready  = in_rdy;
  assign out_valid = valid_q[STAGES-1];
  assign out       = data_q[STAGES-1];
  assign count     = count_q;
  assign busy      = (count_q != '0);

endmodule
